// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - host/control-unit bus bundle for the instruction queue
interface inst_queue_if #(
  parameter int INST_BITS = 16,
  parameter int DEPTH     = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 wr_en;
  logic [INST_BITS-1:0] wr_inst;
  logic                 full;
  logic                 start;
  logic                 halt;
  logic                 flush;
  logic                 cu_flag;
  logic [INST_BITS-1:0] instruction;
  logic [CW-1:0]        count;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic                 err_clr;

  modport master (
    output wr_en, wr_inst, start, halt, flush, cu_flag, err_clr,
    input  full, instruction, count, busy, done, overflow
  );

  modport slave (
    input  wr_en, wr_inst, start, halt, flush, cu_flag, err_clr,
    output full, instruction, count, busy, done, overflow
  );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular instruction FIFO issuing to a control unit; optional INST_QUEUE_OVERFLOW_DETECT_EN
module inst_queue #(
  parameter int                   INST_BITS = 16,
  parameter int                   DEPTH     = 16,
  parameter logic [INST_BITS-1:0] IDLE_WORD = 16'h0000
) (
  input logic         clk,
  input logic         reset_n,
  inst_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [INST_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        cnt;
  state_t               state;
  state_t               state_nxt;
  logic                 done_q;
  logic                 full_w;
  logic                 empty_w;
  logic                 do_push;
  logic                 do_pop;
  logic                 exhaust;
  logic [INST_BITS-1:0] inst_w;
  logic                 busy_w;

  assign full_w  = (cnt == CW'(DEPTH));
  assign empty_w = (cnt == '0);

  // flush and halt suppress pops; only flush suppresses pushes
  assign do_push = bus.wr_en && !full_w && !bus.flush;
  assign do_pop  = (state == RUN) && !empty_w && bus.cu_flag && !bus.flush && !bus.halt;
  assign exhaust = (state == RUN) && empty_w && bus.cu_flag && !bus.flush && !bus.halt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush || bus.halt) begin
      state_nxt = IDLE;
    end else if (state == IDLE) begin
      if (bus.start && !empty_w) begin
        state_nxt = RUN;
      end
    end else if (exhaust) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    busy_w = (state == RUN);
    inst_w = IDLE_WORD;
    if ((state == RUN) && !empty_w) begin
      inst_w = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= bus.wr_inst;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= exhaust;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef INST_QUEUE_OVERFLOW_DETECT_EN
  logic ovf_q;
  logic drop_w;

  // a drop wins over a simultaneous clear so no overflow event is lost
  assign drop_w = bus.wr_en && full_w && !bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop_w) begin
      ovf_q <= 1'b1;
    end else if (bus.err_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.full        = full_w;
  assign bus.count       = cnt;
  assign bus.busy        = busy_w;
  assign bus.done        = done_q;
  assign bus.instruction = inst_w;
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard bench for inst_queue
module tb_inst_queue;
  localparam int IB = 16;
  localparam int DP = 16;
`ifdef INST_QUEUE_OVERFLOW_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic [IB-1:0] exp_q [$];

  inst_queue_if #(.INST_BITS(IB), .DEPTH(DP)) bus ();

  inst_queue #(.INST_BITS(IB), .DEPTH(DP), .IDLE_WORD(16'h0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // issue monitor: every pop the DUT performs must match the scoreboard head
  always @(negedge clk) begin
    if (reset_n && bus.busy && bus.count != 0 && bus.cu_flag && !bus.halt && !bus.flush) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_unexpected: got %0h expected none", bus.instruction);
      end else begin
        check("issue_word", {16'h0, bus.instruction}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [IB-1:0] w, input bit will_issue);
    bus.wr_en   = 1'b1;
    bus.wr_inst = w;
    if (will_issue) exp_q.push_back(w);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_cycles(input int budget, output int dn);
    dn = 0;
    bus.cu_flag = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done) dn++;
    end
    bus.cu_flag = 1'b0;
  endtask

  initial begin
    int dn;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.wr_en = 1'b0; bus.wr_inst = '0; bus.start = 1'b0; bus.halt = 1'b0;
    bus.flush = 1'b0; bus.cu_flag = 1'b0; bus.err_clr = 1'b0;
    repeat (3) tick();
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_instruction", bus.instruction, 16'h0000);
    reset_n = 1'b1;
    tick();

    // basic three-word issue and exhaustion
    push_word(16'h1234, 1'b1);
    push_word(16'h2345, 1'b1);
    push_word(16'h3456, 1'b1);
    check("t1_count", bus.count, 3);
    check("t1_idle_instr", bus.instruction, 16'h0000);
    pulse_start();
    check("t1_busy", bus.busy, 1);
    check("t1_head", bus.instruction, 16'h1234);
    run_cycles(7, dn);
    check("t1_done_once", dn, 1);
    check("t1_busy_fell", bus.busy, 0);
    check("t1_drained", exp_q.size(), 0);
    check("t1_instr_idle", bus.instruction, 16'h0000);

    // fill, overflow, push+pop while full
    for (int i = 0; i < DP; i++) push_word(16'hA000 + 16'(i), 1'b1);
    check("t2_full", bus.full, 1);
    check("t2_count16", bus.count, 16);
    push_word(16'hBEEF, 1'b0);
    check("t2_count_after_drop", bus.count, 16);
    check("t2_overflow", bus.overflow, OVF_EN);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t2_overflow_cleared", bus.overflow, 0);
    pulse_start();
    bus.cu_flag = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_inst = 16'hCAFE;
    tick();
    bus.wr_en = 1'b0;
    check("t2_pushpop_full_count", bus.count, 15);
    check("t2_overflow_pushpop", bus.overflow, OVF_EN);
    run_cycles(19, dn);
    check("t2_done_once", dn, 1);
    check("t2_drained", exp_q.size(), 0);
    check("t2_count0", bus.count, 0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // flush with a simultaneous push
    push_word(16'h0101, 1'b0);
    push_word(16'h0202, 1'b0);
    bus.wr_en = 1'b1; bus.wr_inst = 16'h0303; bus.flush = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.flush = 1'b0;
    check("t3_flush_count", bus.count, 0);
    check("t3_flush_full", bus.full, 0);

    // cu_flag toggling, halt, resume
    push_word(16'h0011, 1'b1);
    push_word(16'h0022, 1'b1);
    push_word(16'h0033, 1'b1);
    push_word(16'h0044, 1'b1);
    push_word(16'h0055, 1'b1);
    pulse_start();
    bus.cu_flag = 1'b1; check("t4_head0", bus.instruction, 16'h0011); tick();
    bus.cu_flag = 1'b0; check("t4_head1", bus.instruction, 16'h0022); tick();
    bus.cu_flag = 1'b1; check("t4_head_held", bus.instruction, 16'h0022); tick();
    bus.cu_flag = 1'b0; check("t4_head3", bus.instruction, 16'h0033); tick();
    check("t4_two_pops", bus.count, 3);
    bus.halt = 1'b1; bus.cu_flag = 1'b1;
    tick();
    bus.halt = 1'b0; bus.cu_flag = 1'b0;
    check("t4_halt_busy", bus.busy, 0);
    check("t4_halt_count", bus.count, 3);
    check("t4_halt_instr", bus.instruction, 16'h0000);
    check("t4_halt_done", bus.done, 0);
    pulse_start();
    check("t4_resume_head", bus.instruction, 16'h0033);
    run_cycles(6, dn);
    check("t4_done_once", dn, 1);
    check("t4_drained", exp_q.size(), 0);

    // 20 words streamed through while running
    push_word(16'h5000, 1'b1);
    pulse_start();
    bus.cu_flag = 1'b1;
    for (int i = 1; i < 20; i++) push_word(16'h5000 + 16'(i), 1'b1);
    check("t5_count_steady", bus.count, 1);
    run_cycles(4, dn);
    check("t5_done_once", dn, 1);
    check("t5_drained", exp_q.size(), 0);

    // asynchronous reset mid-run
    push_word(16'h7001, 1'b1);
    push_word(16'h7002, 1'b1);
    push_word(16'h7003, 1'b1);
    pulse_start();
    bus.cu_flag = 1'b1;
    tick();
    bus.cu_flag = 1'b0;
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_count", bus.count, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_done", bus.done, 0);
    check("t6_rst_instr", bus.instruction, 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_cycles(4, dn);
    check("t6_no_done", dn, 0);
    check("t6_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
